// File: rtl/pdp8_pkg.sv
// ---------------------------------------------------------------------------
// pdp8_pkg : widths, opcode structs and execute-unit state for the PDP-8 core
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pdp8_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 12;
  localparam logic [ADDR_WIDTH-1:0] START_ADDR = 12'o0200;

  typedef struct packed {
    logic op_and;
    logic op_tad;
    logic op_isz;
    logic op_dca;
    logic op_jms;
    logic op_jmp;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic cla;
    logic cll;
    logic cma;
    logic cml;
    logic iac;
    logic rar;
    logic ral;
    logic nop;
    logic hlt;
  } pdp_op7_opcode_s;

  typedef enum logic [2:0] {
    READY   = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    EXEC    = 3'd4,
    HALT    = 3'd5
  } exec_state_e;

  // Instruction class latched at acceptance; steers the later states.
  typedef enum logic [2:0] {
    K_AND = 3'd0,
    K_TAD = 3'd1,
    K_ISZ = 3'd2,
    K_DCA = 3'd3,
    K_JMS = 3'd4,
    K_JMP = 3'd5,
    K_OP7 = 3'd6,
    K_NOP = 3'd7
  } exec_kind_e;

endpackage

`default_nettype wire

// File: rtl/pdp_op7_alu.sv
// ---------------------------------------------------------------------------
// pdp_op7_alu : combinational group-1 operate micro-op evaluation on {L,AC}
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pdp_op7_alu
  import pdp8_pkg::*;
(
  input  logic [DATA_WIDTH:0] lac_in,
  input  pdp_op7_opcode_s     flags,
  output logic [DATA_WIDTH:0] lac_out
);

  logic [DATA_WIDTH:0] clr_s;
  logic [DATA_WIDTH:0] cmp_s;
  logic [DATA_WIDTH:0] inc_s;
  logic                unused_flags;

  assign unused_flags = ^{flags.nop, flags.hlt};

  always_comb begin
    clr_s = lac_in;
    if (flags.cla) clr_s[DATA_WIDTH-1:0] = '0;
    if (flags.cll) clr_s[DATA_WIDTH]     = 1'b0;

    cmp_s = clr_s;
    if (flags.cma) cmp_s[DATA_WIDTH-1:0] = ~clr_s[DATA_WIDTH-1:0];
    if (flags.cml) cmp_s[DATA_WIDTH]     = ~clr_s[DATA_WIDTH];

    // 13-bit increment: the carry out of AC lands on L, complementing it.
    inc_s = flags.iac ? cmp_s + 13'd1 : cmp_s;

    lac_out = inc_s;
    if (flags.rar && !flags.ral)
      lac_out = {inc_s[0], inc_s[DATA_WIDTH:1]};
    else if (flags.ral && !flags.rar)
      lac_out = {inc_s[DATA_WIDTH-1:0], inc_s[DATA_WIDTH]};
  end

endmodule

`default_nettype wire

// File: rtl/instr_exec.sv
// ---------------------------------------------------------------------------
// instr_exec : PDP-8 execute unit for memory-reference and group-1 operates
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_exec
  import pdp8_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  pdp_mem_opcode_s       pdp_mem_opcode,
  input  pdp_op7_opcode_s       pdp_op7_opcode,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] PC_value,
  output logic                  exec_rd_req,
  output logic [ADDR_WIDTH-1:0] exec_rd_addr,
  input  logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_wr_req,
  output logic [ADDR_WIDTH-1:0] exec_wr_addr,
  output logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic [DATA_WIDTH-1:0] ac_out,
  output logic                  link_out
);

  exec_state_e           state_q, state_d;
  exec_kind_e            kind_q, kind_d;
  pdp_op7_opcode_s       op7_q, op7_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] ac_q, ac_d;
  logic [DATA_WIDTH-1:0] mdata_q, mdata_d;
  logic                  link_q, link_d;
  logic [DATA_WIDTH:0]   alu_lac;
  int                    mem_cnt;

  pdp_op7_alu u_op7_alu (
    .lac_in  ({link_q, ac_q}),
    .flags   (op7_q),
    .lac_out (alu_lac)
  );

  assign mem_cnt      = $countones(pdp_mem_opcode);
  assign stall        = (state_q != READY);
  assign PC_value     = pc_q;
  assign ac_out       = ac_q;
  assign link_out     = link_q;
  assign exec_rd_addr = addr_q;
  assign exec_wr_addr = addr_q;

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    op7_d        = op7_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    ac_d         = ac_q;
    mdata_d      = mdata_q;
    link_d       = link_q;
    exec_rd_req  = 1'b0;
    exec_wr_req  = 1'b0;
    exec_wr_data = '0;

    unique case (state_q)
      READY: begin
        addr_d = base_addr;
        if (mem_cnt == 1) begin
          if (pdp_mem_opcode.op_and) begin
            kind_d = K_AND; state_d = RD;
          end else if (pdp_mem_opcode.op_tad) begin
            kind_d = K_TAD; state_d = RD;
          end else if (pdp_mem_opcode.op_isz) begin
            kind_d = K_ISZ; state_d = RD;
          end else if (pdp_mem_opcode.op_dca) begin
            kind_d = K_DCA; state_d = WR;
          end else if (pdp_mem_opcode.op_jms) begin
            kind_d = K_JMS; state_d = WR;
          end else begin
            kind_d = K_JMP; state_d = EXEC;
          end
        end else if (mem_cnt > 1) begin
          kind_d  = K_NOP;
          state_d = EXEC;
        end else if (|pdp_op7_opcode) begin
          kind_d  = K_OP7;
          op7_d   = pdp_op7_opcode;
          state_d = EXEC;
        end
      end

      RD: begin
        exec_rd_req = 1'b1;
        state_d     = RD_WAIT;
      end

      RD_WAIT: begin
        state_d = READY;
        pc_d    = pc_q + 12'd1;
        case (kind_q)
          K_AND:   ac_d = ac_q & exec_rd_data;
          K_TAD:   {link_d, ac_d} = {link_q, ac_q} + {1'b0, exec_rd_data};
          default: begin
            // ISZ keeps the incremented operand for the write that follows.
            mdata_d = exec_rd_data + 12'd1;
            pc_d    = pc_q;
            state_d = WR;
          end
        endcase
      end

      WR: begin
        exec_wr_req = 1'b1;
        state_d     = READY;
        case (kind_q)
          K_ISZ: begin
            exec_wr_data = mdata_q;
            pc_d         = pc_q + ((mdata_q == '0) ? 12'd2 : 12'd1);
          end
          K_DCA: begin
            exec_wr_data = ac_q;
            ac_d         = '0;
            pc_d         = pc_q + 12'd1;
          end
          default: begin
            exec_wr_data = pc_q + 12'd1;
            pc_d         = addr_q + 12'd1;
          end
        endcase
      end

      EXEC: begin
        state_d = READY;
        case (kind_q)
          K_JMP: pc_d = addr_q;
          K_OP7: begin
            {link_d, ac_d} = alu_lac;
            pc_d           = pc_q + 12'd1;
            if (op7_q.hlt) state_d = HALT;
          end
          default: pc_d = pc_q + 12'd1;
        endcase
      end

      HALT: state_d = HALT;

      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= READY;
      kind_q  <= K_NOP;
      op7_q   <= '0;
      pc_q    <= START_ADDR;
      addr_q  <= '0;
      ac_q    <= '0;
      mdata_q <= '0;
      link_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      op7_q   <= op7_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ac_q    <= ac_d;
      mdata_q <= mdata_d;
      link_q  <= link_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/instr_exec.md
INSTR_EXEC -- requirements
Module: instr_exec

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port base_addr  input  `ADDR_WIDTH (12)  effective address from the decoder, indirection already resolved.
REQ-004 SHALL have port pdp_mem_opcode  input  pdp_mem_opcode_s  one-hot AND/TAD/ISZ/DCA/JMS/JMP fields.
REQ-005 SHALL have port pdp_op7_opcode  input  pdp_op7_opcode_s  group-1 micro-op flags (CLA, CLL, CMA, CML, IAC, RAR, RAL, NOP, HLT).
REQ-006 SHALL have port stall  output  1  high while an instruction is executing or the unit is halted.
REQ-007 SHALL have port PC_value  output  `ADDR_WIDTH  address of the next instruction to fetch.
REQ-008 SHALL have ports exec_rd_req (out, 1), exec_rd_addr (out, 12), exec_rd_data (in, 12)  data read port; data valid one cycle after the request.
REQ-009 SHALL have ports exec_wr_req (out, 1), exec_wr_addr (out, 12), exec_wr_data (out, 12)  data write port; write commits in the request cycle.
REQ-010 SHALL have ports ac_out (out, 12) and link_out (out, 1)  architectural AC and L, for checkers.

Function
REQ-011 SHALL accept an instruction on a rising edge where state is READY and exactly one pdp_mem_opcode field or any pdp_op7_opcode field is set; it SHALL ignore inputs in every other cycle.
REQ-012 SHALL implement states READY, RD, RD_WAIT, WR, EXEC and HALT; stall SHALL be 0 only in READY.
REQ-013 After acceptance, it SHALL run the following state sequences: JMP and op7 -> EXEC; AND and TAD -> RD, RD_WAIT; ISZ -> RD, RD_WAIT, WR; DCA and JMS -> WR; the final state of each sequence SHALL return to READY.
REQ-014 In RD, exec_rd_req SHALL be 1 with exec_rd_addr=base_addr latched at acceptance; in RD_WAIT, exec_rd_data SHALL be captured.
REQ-015 AND SHALL compute AC<=AC&M; TAD SHALL compute {L,AC}<={L,AC}+M, with a carry out of bit 11 complementing L.
REQ-016 ISZ SHALL write M+1 (mod 2^12); PC SHALL advance by 2 if the written value is 0, otherwise by 1.
REQ-017 DCA SHALL write AC and then clear AC; JMS SHALL write PC+1 to base_addr and set PC<=base_addr+1; JMP SHALL set PC<=base_addr.
REQ-018 All other instructions SHALL set PC<=PC+1; all PC arithmetic SHALL wrap modulo 4096 (7777 -> 0000).
REQ-019 op7 SHALL be evaluated in one cycle in this order: CLA/CLL; then CMA/CML; then IAC (carry complements L); then RAR/RAL through L; if both RAR and RAL are set, no rotate SHALL occur.
REQ-020 HLT SHALL apply its co-specified micro-ops, advance PC by 1 and enter HALT; stall SHALL stay 1 until reset.
REQ-021 PC_value, AC and L SHALL update on the edge leaving the final state, so that stall falls in the same cycle the new PC_value appears.
REQ-022 exec_rd_req and exec_wr_req SHALL never be 1 in the same cycle and SHALL be 0 in READY, EXEC and HALT.
REQ-023 When more than one pdp_mem_opcode field is set, the input SHALL be treated as NOP (PC+1 via EXEC).

Reset
REQ-024 On reset_n low, the unit SHALL asynchronously set state=READY, stall=0, PC_value=0200 (octal), AC=0, L=0, and clear all request outputs; reset mid-instruction SHALL abort the instruction with no further write.

Structure
REQ-025 ADDR_WIDTH, DATA_WIDTH, START_ADDR (0200), pdp_mem_opcode_s, pdp_op7_opcode_s and the state enum SHALL reside in the shared pdp8 package.
REQ-026 op7 evaluation SHALL be a combinational sub-module pdp_op7_alu ({L,AC} and flags in, {L,AC} out).

Verification
REQ-027 Case 1: after reset, with JMP to 0345 -> stall is 1 for one cycle, then PC_value=0345 and no memory requests are issued.
REQ-028 Case 2: AC=7777, L=0, TAD with M[0100]=0001 -> AC=0000, L=1, PC+1, stall is 1 for two cycles.
REQ-029 Case 3: ISZ with M[0050]=7777 -> write of 0000 to 0050, and PC advances by 2; a second case with M=0005 -> write of 0006, and PC advances by 1.
REQ-030 Case 4: JMS 0400 at PC=0210 -> write of 0211 to address 0400, then PC_value=0401.
REQ-031 Case 5: op7 with CLA+CMA+IAC, L=0 -> AC=0000, L=1; op7 with RAL on AC=4000, L=0 -> AC=0000, L=1.
REQ-032 Case 6: reset asserted in the RD_WAIT state of a TAD -> no AC change, PC_value=0200, stall=0; HLT -> stall held at 1 for more than 100 cycles.
